// File: rtl/tc_clk_div_bank.sv
// rtl/tc_clk_div_bank.sv - bank of glitch-free integer clock dividers
// Each channel divides clk_i by a ratio that is only ever swapped on its own period boundary.
module tc_clk_div_bank #(
    parameter int NUM_CH      = 2,
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 test_mode_i,
    input  logic [NUM_CH-1:0]    en_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [CH_W-1:0]      cfg_ch_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    output logic [NUM_CH-1:0]    clk_o,
    output logic [NUM_CH-1:0]    active_o
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV =
        (DEFAULT_DIV < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [31:0]          w_ch_ext;
    logic [NUM_CH-1:0]    w_pend;
    logic                 w_ready;
    logic [DIV_WIDTH-1:0] w_div_clamp;

    assign w_ch_ext    = 32'(cfg_ch_i);
    assign w_div_clamp = (cfg_div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div_i;

    // Out-of-range channels stay ready so their beats are swallowed.
    always_comb begin
        w_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch_ext == 32'(c)) w_ready = ~w_pend[c];
        end
    end
    assign cfg_ready_o = w_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t               r_state, w_state_nx;
        logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nx;
        logic [DIV_WIDTH-1:0] r_div_cur, w_div_cur_nx, r_div_pend;
        logic                 r_pend, r_q, w_q_nx, w_apply, w_acc, w_boundary;
        logic [DIV_WIDTH-1:0] w_hi;
        logic [DIV_WIDTH:0]   w_cnt_inc;

        assign w_hi       = r_div_cur >> 1;
        assign w_cnt_inc  = {1'b0, r_cnt} + (DIV_WIDTH+1)'(1);
        assign w_boundary = (r_cnt == r_div_cur - DIV_WIDTH'(1));
        assign w_acc      = cfg_valid_i & w_ready & (w_ch_ext == 32'(c));

        always_comb begin
            w_state_nx   = r_state;
            w_cnt_nx     = r_cnt;
            w_q_nx       = r_q;
            w_div_cur_nx = r_div_cur;
            w_apply      = 1'b0;
            case (r_state)
                S_IDLE: begin
                    w_cnt_nx = '0;
                    w_q_nx   = 1'b0;
                    if (en_i[c]) begin
                        w_state_nx = S_RUN;
                        w_q_nx     = 1'b1;
                        w_apply    = r_pend;
                    end
                end
                S_RUN: begin
                    if (w_boundary) begin
                        w_cnt_nx = '0;
                        w_apply  = r_pend;
                        if (en_i[c]) begin
                            w_q_nx = 1'b1;
                        end else begin
                            w_q_nx     = 1'b0;
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_cnt_nx = w_cnt_inc[DIV_WIDTH-1:0];
                        w_q_nx   = (w_cnt_inc < {1'b0, w_hi});
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
            if (w_apply) w_div_cur_nx = r_div_pend;
        end

        // Accept only happens while pend is clear, so it never races the apply.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_q        <= 1'b0;
                r_div_cur  <= DEF_DIV;
                r_div_pend <= DEF_DIV;
                r_pend     <= 1'b0;
            end else begin
                r_state   <= w_state_nx;
                r_cnt     <= w_cnt_nx;
                r_q       <= w_q_nx;
                r_div_cur <= w_div_cur_nx;
                if (w_apply) r_pend <= 1'b0;
                if (w_acc) begin
                    r_pend     <= 1'b1;
                    r_div_pend <= w_div_clamp;
                end
            end
        end

        assign w_pend[c]   = r_pend;
        assign active_o[c] = (r_state == S_RUN);
        assign clk_o[c]    = test_mode_i ? clk_i : r_q;
    end

endmodule

// File: tb/tb_tc_clk_div_bank.sv
// tb/tb_tc_clk_div_bank.sv - scoreboard bench for tc_clk_div_bank
// A period-position model pushes per-edge expectations; a negedge monitor pops and compares.
module tb_tc_clk_div_bank;
    localparam int N  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tm  = 1'b0;
    logic [N-1:0]  en  = '0;
    logic          cv  = 1'b0;
    logic [1:0]    cch = '0;
    logic [DW-1:0] cdiv = '0;
    logic          cfg_ready;
    logic [N-1:0]  clk_o, act;

    int tests = 0;
    int fails = 0;

    tc_clk_div_bank #(.NUM_CH(N), .DIV_WIDTH(DW), .DEFAULT_DIV(2)) dut (
        .clk_i(clk), .rst_i(rst), .test_mode_i(tm), .en_i(en),
        .cfg_valid_i(cv), .cfg_ready_o(cfg_ready), .cfg_ch_i(cch),
        .cfg_div_i(cdiv), .clk_o(clk_o), .active_o(act)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] act;
        logic [N-1:0] pend;
    } exp_t;
    exp_t sb[$];

    bit m_run[N];
    int m_p[N], m_div[N], m_pdiv[N];
    bit m_pend[N];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
        end
    endtask

    // Model: each running channel sits at position p of a div-long period, high while p < div/2.
    always @(posedge clk) begin
        exp_t e;
        bit acc;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_run[c] = 0; m_p[c] = 0; m_div[c] = 2; m_pdiv[c] = 2; m_pend[c] = 0;
            end
        end else begin
            acc = 0;
            if (cv) begin
                if (cch >= N) acc = 1;
                else acc = !m_pend[cch];
            end
            for (int c = 0; c < N; c++) begin
                if (!m_run[c]) begin
                    if (en[c]) begin
                        m_run[c] = 1; m_p[c] = 0;
                        if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
                    end
                end else if (m_p[c] == m_div[c] - 1) begin
                    m_p[c] = 0;
                    if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
                    if (!en[c]) m_run[c] = 0;
                end else begin
                    m_p[c]++;
                end
            end
            if (acc && cch < N) begin
                m_pend[cch] = 1;
                m_pdiv[cch] = (cdiv < 2) ? 2 : int'(cdiv);
            end
        end
        for (int c = 0; c < N; c++) begin
            e.q[c]    = m_run[c] && (m_p[c] < m_div[c] / 2);
            e.act[c]  = m_run[c];
            e.pend[c] = m_pend[c];
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        logic xr;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rst) begin
                chk("clk_o_in_reset", 32'(clk_o), 32'd0);
                chk("active_o_in_reset", 32'(act), 32'd0);
                chk("cfg_ready_o_in_reset", 32'(cfg_ready), 32'd1);
            end else begin
                chk("clk_o", 32'(clk_o), tm ? 32'd0 : 32'(e.q));
                chk("active_o", 32'(act), 32'(e.act));
                xr = (cch >= N) ? 1'b1 : !e.pend[cch];
                chk("cfg_ready_o", 32'(cfg_ready), 32'(xr));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int d);
        cv = 1'b1; cch = 2'(ch); cdiv = DW'(d);
        step(1);
        cv = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        en  = 3'b001;
        step(8);
        cfg(0, 3); step(9);
        cfg(0, 4); step(10);
        cfg(0, 0); step(6);
        cfg(0, 1); step(6);
        // Drop enable at p=1 of a div-6 period.
        cfg(0, 6);
        for (int i = 0; i < 20 && !(m_div[0] == 6 && m_p[0] == 1); i++) step(1);
        en[0] = 1'b0; step(10);
        en[0] = 1'b1; step(10);
        en = 3'b011;
        cfg(0, 5); cfg(1, 7); cfg(3, 9);
        step(30);
        step(1);
        tm = 1'b1;
        #1 chk("bypass_high", 32'(clk_o), 32'h7);
        step(5);
        tm = 1'b0;
        step(10);
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) if ($urandom_range(15) == 0) en[c] = ~en[c];
            if ($urandom_range(3) == 0) begin
                cv = 1'b1; cch = 2'($urandom_range(3)); cdiv = DW'($urandom_range(9));
            end else begin
                cv = 1'b0;
            end
            step(1);
        end
        cv = 1'b0; cch = 2'd0;
        en = 3'b111;
        for (int i = 0; i < 30 && !(m_run[0] && m_p[0] < m_div[0] / 2); i++) step(1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_clk_o", 32'(clk_o), 32'd0);
        chk("async_reset_active_o", 32'(act), 32'd0);
        step(2);
        rst = 1'b0;
        en  = 3'b001;
        step(10);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
